// File: rtl/audio_pattern_generator.sv
// Multi-channel audio test-pattern generator: silence, square, sawtooth and
// sine per channel, produced one frame at a time behind a valid/ready handshake.
// A single synchronous-read sine ROM is time-shared across channels in CALC.
module audio_pattern_generator #(
    parameter int SAMPLE_WIDTH   = 24,
    parameter int CHANNELS       = 2,
    parameter int PHASE_WIDTH    = 16,
    parameter int LUT_ADDR_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             cfg_load,
    input  logic [2*CHANNELS-1:0]            cfg_mode,
    input  logic [PHASE_WIDTH*CHANNELS-1:0]  cfg_phase_inc,
    input  logic                             ready,
    output logic                             valid,
    output logic [SAMPLE_WIDTH*CHANNELS-1:0] out
);

    localparam int unsigned LUT_DEPTH = 2 ** LUT_ADDR_WIDTH;
    localparam int          CW        = $clog2(CHANNELS + 1);
    localparam int          IW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [CW-1:0]           LAST_CNT = CW'(CHANNELS);
    localparam logic [SAMPLE_WIDTH-1:0] POS_MAX  = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic [SAMPLE_WIDTH-1:0] NEG_MAX  = -POS_MAX;
    localparam logic [PHASE_WIDTH-1:0]  PH_MSB   = PHASE_WIDTH'(1) << (PHASE_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, PRESENT} state_t;
    typedef logic [LUT_DEPTH-1:0][SAMPLE_WIDTH-1:0] rom_t;

    // Table of round(MAX*sin(2*pi*k/N)), evaluated at elaboration.
    // Upper half is folded to negative angles to keep the series well conditioned.
    function automatic rom_t build_sine();
        rom_t tbl;
        real  pi_c, amp, x, term, acc;
        int   k_signed, rounded;
        tbl  = '0;
        pi_c = 3.14159265358979323846;
        amp  = real'((longint'(1) << (SAMPLE_WIDTH - 1)) - 1);
        for (int unsigned k = 0; k < LUT_DEPTH; k++) begin
            k_signed = (k > LUT_DEPTH / 2) ? int'(k) - int'(LUT_DEPTH) : int'(k);
            x        = 2.0 * pi_c * real'(k_signed) / real'(LUT_DEPTH);
            term     = x;
            acc      = x;
            for (int unsigned n = 1; n < 14; n++) begin
                term = -term * x * x / real'((2 * n) * (2 * n + 1));
                acc  = acc + term;
            end
            acc     = amp * acc;
            rounded = (acc >= 0.0) ? $rtoi(acc + 0.5) : -$rtoi(0.5 - acc);
            tbl[k[LUT_ADDR_WIDTH-1:0]] = SAMPLE_WIDTH'(rounded);
        end
        return tbl;
    endfunction

    localparam rom_t SINE_ROM = build_sine();

    state_t                                state_q, state_d;
    logic [CW-1:0]                         cnt_q, cnt_d;
    logic [CHANNELS-1:0][PHASE_WIDTH-1:0]  phase_q, phase_d;
    logic [CHANNELS-1:0][PHASE_WIDTH-1:0]  shadow_inc_q, shadow_inc_d;
    logic [CHANNELS-1:0][PHASE_WIDTH-1:0]  active_inc_q, active_inc_d;
    logic [CHANNELS-1:0][1:0]              shadow_mode_q, shadow_mode_d;
    logic [CHANNELS-1:0][1:0]              active_mode_q, active_mode_d;
    logic [CHANNELS-1:0][SAMPLE_WIDTH-1:0] out_q, out_d;
    logic [SAMPLE_WIDTH-1:0]               rom_q;
    logic [LUT_ADDR_WIDTH-1:0]             rom_addr;
    logic [IW-1:0]                         rd_idx, wr_idx;
    logic [PHASE_WIDTH-1:0]                wr_phase;
    logic [SAMPLE_WIDTH-1:0]               sample;

    assign valid = (state_q == PRESENT);
    assign out   = out_q;

    // CALC cycle c issues the ROM address for channel c and writes channel c-1.
    always_comb begin
        rd_idx   = (cnt_q < LAST_CNT) ? IW'(cnt_q) : '0;
        wr_idx   = (cnt_q == '0) ? '0 : IW'(cnt_q - CW'(1));
        rom_addr = phase_q[rd_idx][PHASE_WIDTH-1 -: LUT_ADDR_WIDTH];
        wr_phase = phase_q[wr_idx];
        sample   = '0;
        case (active_mode_q[wr_idx])
            2'd1:    sample = wr_phase[PHASE_WIDTH-1] ? NEG_MAX : POS_MAX;
            2'd2:    sample = SAMPLE_WIDTH'({wr_phase ^ PH_MSB, {SAMPLE_WIDTH{1'b0}}} >> PHASE_WIDTH);
            2'd3:    sample = rom_q;
            default: sample = '0;
        endcase
    end

    // Next-state logic: frame sequencing, config shadow/active transfer, phase advance.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        phase_d       = phase_q;
        out_d         = out_q;
        active_mode_d = active_mode_q;
        active_inc_d  = active_inc_q;
        shadow_mode_d = cfg_load ? cfg_mode      : shadow_mode_q;
        shadow_inc_d  = cfg_load ? cfg_phase_inc : shadow_inc_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d       = CALC;
                    cnt_d         = '0;
                    active_mode_d = shadow_mode_d;
                    active_inc_d  = shadow_inc_d;
                end
            end
            CALC: begin
                if (cnt_q != '0) begin
                    out_d[wr_idx] = sample;
                end
                if (cnt_q == LAST_CNT) begin
                    state_d = PRESENT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESENT: begin
                if (ready) begin
                    for (int unsigned i = 0; i < CHANNELS; i++) begin
                        phase_d[i] = phase_q[i] + active_inc_q[i];
                    end
                    if (enable) begin
                        state_d       = CALC;
                        cnt_d         = '0;
                        // shadow_d so a cfg_load on the accept edge takes effect now
                        active_mode_d = shadow_mode_d;
                        active_inc_d  = shadow_inc_d;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            phase_q       <= '0;
            shadow_inc_q  <= '0;
            active_inc_q  <= '0;
            shadow_mode_q <= '0;
            active_mode_q <= '0;
            out_q         <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            phase_q       <= phase_d;
            shadow_inc_q  <= shadow_inc_d;
            active_inc_q  <= active_inc_d;
            shadow_mode_q <= shadow_mode_d;
            active_mode_q <= active_mode_d;
            out_q         <= out_d;
        end
    end

    // Single-port synchronous-read sine ROM.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_q <= '0;
        end else begin
            rom_q <= SINE_ROM[rom_addr];
        end
    end

endmodule

// File: tb/tb_audio_pattern_generator.sv
// Directed testbench for audio_pattern_generator (24-bit, 2 channels,
// 16-bit phase, 256-entry sine table).
module tb_audio_pattern_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        cfg_load;
    logic [3:0]  cfg_mode;
    logic [31:0] cfg_phase_inc;
    logic        ready;
    logic        valid;
    logic [47:0] out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    audio_pattern_generator #(
        .SAMPLE_WIDTH  (24),
        .CHANNELS      (2),
        .PHASE_WIDTH   (16),
        .LUT_ADDR_WIDTH(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .cfg_load     (cfg_load),
        .cfg_mode     (cfg_mode),
        .cfg_phase_inc(cfg_phase_inc),
        .ready        (ready),
        .valid        (valid),
        .out          (out)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Three cycles with valid low, then a presented frame with the given samples.
    task automatic frame(input string tag, input logic [23:0] e0, input logic [23:0] e1);
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            cfg_load = 1'b0;
            check_eq({tag, "_lo"}, 64'(valid), 64'd0);
        end
        tick();
        check_eq({tag, "_valid"}, 64'(valid), 64'd1);
        check_eq({tag, "_ch0"}, 64'(out[23:0]), 64'(e0));
        check_eq({tag, "_ch1"}, 64'(out[47:24]), 64'(e1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        enable        = 1'b0;
        cfg_load      = 1'b0;
        cfg_mode      = '0;
        cfg_phase_inc = '0;
        ready         = 1'b0;
        tick();
        tick();
        check_eq("rst_valid", 64'(valid), 64'd0);
        check_eq("rst_out", 64'(out), 64'd0);
        reset = 1'b0;

        // Sine, inc 0x0100 on both channels.
        cfg_load      = 1'b1;
        cfg_mode      = 4'hF;
        cfg_phase_inc = {16'h0100, 16'h0100};
        tick();
        cfg_load = 1'b0;
        check_eq("idle_valid", 64'(valid), 64'd0);
        enable = 1'b1;
        ready  = 1'b1;
        frame("v1_f0", 24'd0, 24'd0);
        frame("v1_f1", 24'd205867, 24'd205867);

        // Stall in PRESENT.
        ready = 1'b0;
        for (int unsigned i = 0; i < 10; i++) begin
            tick();
            check_eq("v2_hold_valid", 64'(valid), 64'd1);
            check_eq("v2_hold_out", 64'(out), 64'({24'd205867, 24'd205867}));
        end
        ready = 1'b1;
        frame("v2_f2", 24'd411609, 24'd411609);

        // Reconfigure to sawtooth, inc 0x0200, while a frame is held.
        ready         = 1'b0;
        cfg_load      = 1'b1;
        cfg_mode      = 4'hA;
        cfg_phase_inc = {16'h0200, 16'h0200};
        tick();
        cfg_load = 1'b0;
        check_eq("v5_hold_valid", 64'(valid), 64'd1);
        check_eq("v5_hold_out", 64'(out), 64'({24'd411609, 24'd411609}));
        tick();
        check_eq("v5_hold2_out", 64'(out), 64'({24'd411609, 24'd411609}));
        ready = 1'b1;
        frame("v5_f3", 24'h830000, 24'h830000);
        frame("v5_f4", 24'h850000, 24'h850000);

        // cfg_load coincident with accept: ch0 square inc 0x8000, ch1 silence.
        cfg_load      = 1'b1;
        cfg_mode      = 4'b0001;
        cfg_phase_inc = {16'h0000, 16'h8000};
        frame("v3_f5", 24'h7FFFFF, 24'h000000);
        frame("v3_f6", 24'h800001, 24'h000000);
        frame("v3_f7", 24'h7FFFFF, 24'h000000);

        // Reset during PRESENT, with a simultaneous cfg_load that must lose.
        ready = 1'b0;
        tick();
        check_eq("v6_pre_valid", 64'(valid), 64'd1);
        reset         = 1'b1;
        cfg_load      = 1'b1;
        cfg_mode      = 4'hF;
        cfg_phase_inc = {16'h1234, 16'h1234};
        tick();
        reset    = 1'b0;
        cfg_load = 1'b0;
        check_eq("v6_rst_valid", 64'(valid), 64'd0);
        check_eq("v6_rst_out", 64'(out), 64'd0);
        ready = 1'b1;
        frame("v6_f0", 24'd0, 24'd0);

        // Sawtooth, inc 0x4000 from phase 0, loaded on the accept edge.
        cfg_load      = 1'b1;
        cfg_mode      = 4'hA;
        cfg_phase_inc = {16'h4000, 16'h4000};
        frame("v4_f0", 24'h800000, 24'h800000);
        frame("v4_f1", 24'hC00000, 24'hC00000);
        frame("v4_f2", 24'h000000, 24'h000000);
        frame("v4_f3", 24'h400000, 24'h400000);
        frame("v4_f4", 24'h800000, 24'h800000);

        // Drop enable mid-CALC: frame still completes, then IDLE holds out.
        tick();
        enable = 1'b0;
        check_eq("en_calc_lo0", 64'(valid), 64'd0);
        tick();
        check_eq("en_calc_lo1", 64'(valid), 64'd0);
        tick();
        check_eq("en_calc_lo2", 64'(valid), 64'd0);
        tick();
        check_eq("en_last_valid", 64'(valid), 64'd1);
        check_eq("en_last_ch0", 64'(out[23:0]), 64'h00C00000);
        tick();
        for (int unsigned i = 0; i < 5; i++) begin
            check_eq("idle_end_valid", 64'(valid), 64'd0);
            check_eq("idle_end_out", 64'(out), 64'({24'hC00000, 24'hC00000}));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/audio_pattern_generator.md
AUDIO_PATTERN_GENERATOR -- requirements
Module: audio_pattern_generator

Interface
REQ-001 Parameter SAMPLE_WIDTH, default 24: bits per channel sample, two's complement.
REQ-002 Parameter CHANNELS, default 2: number of independent channels, valid range 1..8.
REQ-003 Parameter PHASE_WIDTH, default 16: per-channel phase accumulator width.
REQ-004 Parameter LUT_ADDR_WIDTH, default 8: sine table has 2^LUT_ADDR_WIDTH entries; PHASE_WIDTH >= LUT_ADDR_WIDTH is a legal configuration only.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  level; 1 = generate frames.
REQ-008 cfg_load  input  1  single-cycle strobe capturing cfg_mode and cfg_phase_inc into shadow registers.
REQ-009 cfg_mode  input  2*CHANNELS  per-channel mode, ch i at [2i+1:2i]: 0 silence, 1 square, 2 sawtooth, 3 sine.
REQ-010 cfg_phase_inc  input  PHASE_WIDTH*CHANNELS  per-channel phase increment, ch i at lowest index slice i.
REQ-011 ready  input  1  downstream accepts frame when high.
REQ-012 valid  output  1  frame on out is valid.
REQ-013 out  output  SAMPLE_WIDTH*CHANNELS  frame, ch 0 in LSBs.

Function
REQ-014 States IDLE, CALC, PRESENT; valid SHALL be 1 exactly in PRESENT.
REQ-015 IDLE: enable=1 -> CALC; else stay; out holds last value.
REQ-016 On every entry to CALC, shadow config SHALL be copied to active config, atomically for all channels.
REQ-017 CALC SHALL last exactly CHANNELS+1 cycles using one single-port synchronous-read sine ROM shared across channels (ch i address issued cycle i, data captured cycle i+1), then -> PRESENT.
REQ-018 Latency: enable sampled high at edge k -> valid high after edge k+CHANNELS+1.
REQ-019 PRESENT: out and valid SHALL hold stable while ready=0; phase accumulators SHALL not change.
REQ-020 Accept = valid&ready at an edge: every phase[i] += active inc[i] modulo 2^PHASE_WIDTH; next state CALC if enable=1, else IDLE; valid low for the following CHANNELS+1 cycles.
REQ-021 enable deassertion during CALC or PRESENT SHALL NOT abort the frame; frame is completed and handshaken before IDLE.
REQ-022 Frame n uses pre-increment phase; first frame after reset uses phase 0.
REQ-023 MAX = 2^(SAMPLE_WIDTH-1)-1. Silence: 0. Square: phase MSB 0 -> +MAX, 1 -> -MAX. Sawtooth: phase with MSB inverted, left-aligned to SAMPLE_WIDTH (truncate LSBs if PHASE_WIDTH>SAMPLE_WIDTH, zero-pad if smaller). Sine: ROM[phase top LUT_ADDR_WIDTH bits], ROM[k] = round(MAX*sin(2*pi*k/2^LUT_ADDR_WIDTH)).
REQ-024 cfg_load during CALC/PRESENT SHALL affect only shadow registers; current frame and its accept-time increment use the old active config; the new config applies from the next CALC.
REQ-025 cfg_load coincident with accept: shadow updated that edge; new config is active for the immediately following CALC.
REQ-026 cfg_load in the same cycle as reset: reset wins, shadow takes reset values.

Reset
REQ-027 reset=1 at an edge, in any state: state IDLE, valid 0, out 0, all phases 0, shadow and active modes 0 (silence), increments 0.
REQ-028 reset mid-CALC or mid-PRESENT SHALL drop valid after that edge with no handshake of the pending frame.

Verification (SAMPLE_WIDTH=24, CHANNELS=2, PHASE_WIDTH=16, LUT_ADDR_WIDTH=8)
V1 reset; cfg_load mode sine both, inc 0x0100; enable=1, ready=1 -> valid rises 3 cycles after enable; frames ch0=ch1: 0, 205867, ...; valid low 3 cycles between frames.
V2 sine inc 0x0100, ready=0 for 10 cycles in PRESENT -> valid 1, out constant; after ready=1 next frame advances exactly one step.
V3 square inc 0x8000 -> ch0 alternates 0x7FFFFF, 0x800001; ch1 silence -> 0x000000 throughout.
V4 saw inc 0x4000 -> 0x800000, 0xC00000, 0x000000, 0x400000, then wraps to 0x800000.
V5 cfg_load inc 0x0200 while PRESENT with old inc 0x0100 -> presented frame unchanged; next phase = old+0x0100; subsequent steps 0x0200.
V6 reset pulsed during PRESENT -> valid 0 and out 0 next cycle; with enable=1 first new frame is phase 0 and silence until cfg_load.
